// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M encodings and multiply/divide FSM state constants
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef logic [1:0] muldiv_state_t;

    localparam muldiv_state_t ST_IDLE = 2'd0;
    localparam muldiv_state_t ST_CALC = 2'd1;
    localparam muldiv_state_t ST_FIX  = 2'd2;
    localparam muldiv_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 step: shift-add multiply or restoring divide
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   rem_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out,
    output logic [XLEN-1:0]   rem_out,
    output logic              q_bit
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        shifted = {rem_in, acc_in[XLEN-1]};
        // A set sign bit means the trial subtraction went negative: restore.
        trial   = shifted - {1'b0, operand};
        q_bit   = ~trial[XLEN];
        acc_out = acc_in;
        rem_out = rem_in;
        if (is_div) begin
            rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
            acc_out = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-2:0], 1'b0};
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit, one radix-2 step per clock
module muldiv_iter
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] register_data_1,
    input  logic [XLEN-1:0] register_data_2,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] register_data_out
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic              neg_main;
    logic              neg_rem;
    logic              special;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN-1:0]   result;

    logic              accept;
    logic              s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, ovf, spec_now;
    logic [XLEN-1:0]   spec_val_now;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, remv, fix_val;

    always_comb begin
        accept = (state == ST_IDLE) && enable && (funct7 == FUNCT7_MULDIV);
        s1 = (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && register_data_1[XLEN-1];
        s2 = (funct3 inside {F3_MULH, F3_DIV, F3_REM}) && register_data_2[XLEN-1];
        mag1 = s1 ? -register_data_1 : register_data_1;
        mag2 = s2 ? -register_data_2 : register_data_2;
        div_zero = funct3[2] && (register_data_2 == '0);
        ovf = (funct3 inside {F3_DIV, F3_REM}) && (register_data_1 == SMIN) && (register_data_2 == '1);
        spec_now = div_zero || ovf;
        // funct3[1] separates the remainder ops from the quotient ops.
        if (div_zero) begin
            spec_val_now = funct3[1] ? register_data_1 : '1;
        end else begin
            spec_val_now = funct3[1] ? '0 : register_data_1;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op[2]),
        .acc_in  (acc),
        .rem_in  (rem),
        .operand (operand),
        .acc_out (step_acc),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        prod = neg_main ? -acc : acc;
        quot = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remv = neg_rem ? -rem : rem;
        case (op)
            F3_MUL:                       fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = quot;
            default:                      fix_val = remv;
        endcase
        if (special) begin
            fix_val = spec_val;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            op       <= '0;
            operand  <= '0;
            acc      <= '0;
            rem      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            special  <= 1'b0;
            spec_val <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op       <= funct3;
                        neg_main <= s1 ^ s2;
                        neg_rem  <= s1;
                        special  <= spec_now;
                        spec_val <= spec_val_now;
                        count    <= '0;
                        rem      <= '0;
                        // Divide shifts the dividend out of acc; multiply shifts the multiplier.
                        if (funct3[2]) begin
                            acc     <= {{XLEN{1'b0}}, mag1};
                            operand <= mag2;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, mag2};
                            operand <= mag1;
                        end
                        if (FAST_SPECIAL && spec_now) begin
                            result <= spec_val_now;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc   <= op[2] ? {step_acc[2*XLEN-1:1], step_q} : step_acc;
                    rem   <= step_rem;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result <= fix_val;
                    state  <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy              = (state == ST_CALC) || (state == ST_FIX);
    assign out_valid         = (state == ST_DONE);
    assign register_data_out = result;

endmodule
